hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Consumer-side controller for the ID/EX pipeline register: reads the ID/EX outputs and the IF/ID operand fields.
//  Detects load-use hazards and taken branches.
//  Drives PC/IF-ID write enables, ID/EX bubble injection and per-stage flushes.
//  Sits beside the decode stage; its stall/flush outputs feed PC, IF_ID, ID_EX and EX_MEM.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   stall cycles per load-use hazard (1..15), covers multi-cycle data memory
//  CNT_W              32  width of performance counters
// PORTS
//  clock               in   1      rising-edge clock
//  reset               in   1      synchronous, active-high reset
//  id_ex_MemRead       in   1      ID/EX MemRead_out (instruction in EX is a load)
//  id_ex_write_reg     in   5      ID/EX write_register_out
//  if_id_read_reg1     in   5      Rn of instruction in decode
//  if_id_read_reg2     in   5      Rm/Rt of instruction in decode
//  if_id_uses_reg2     in   1      decode instruction reads read_reg2 (R-type, STUR, CBZ)
//  branch_taken        in   1      branch resolved taken in MEM (PCSrc)
//  pc_write            out  1      1 = PC may update
//  if_id_write         out  1      1 = IF/ID may load
//  id_ex_bubble        out  1      1 = ID/EX loads all-zero controls (NOP)
//  if_id_flush         out  1      clear IF/ID
//  id_ex_flush         out  1      clear ID/EX
//  ex_mem_flush        out  1      clear EX/MEM controls
//  stall_count         out  CNT_W  cycles spent stalled (see CONFIGURATION)
//  flush_count         out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  - FSM states: RUN, STALL. Internal stall counter cnt[3:0].
//  - Reset: state=RUN, cnt=0, counters=0.
//  - Outputs are combinational from state and inputs, so they act in the cycle the hazard is seen.
//    While reset is high, outputs take their RUN/no-hazard values.
//  - Hazard: hz = id_ex_MemRead && id_ex_write_reg!=5'd31 (XZR never hazards) &&
//    (id_ex_write_reg==if_id_read_reg1 || (if_id_uses_reg2 && id_ex_write_reg==if_id_read_reg2)).
//  - RUN, no hz, no branch: pc_write=1, if_id_write=1; all other outputs 0.
//  - RUN, hz: pc_write=0, if_id_write=0, id_ex_bubble=1.
//    If LOAD_STALL_CYCLES>1: go to STALL, cnt=LOAD_STALL_CYCLES-1. Else stay in RUN.
//  - STALL: same outputs as RUN+hz; cnt decrements each cycle; when cnt==1, next state is RUN.
//    hz is ignored in STALL, because the bubble is now in EX.
//  - branch_taken (any state): if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0.
//    Next state is RUN, cnt=0. Branch has priority over hz and aborts a STALL.
//  - hz and branch_taken in the same cycle: the flush wins; no stall cycle is counted.
//  - Reset mid-STALL: returns to RUN next edge; no residual stall.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined:
//    - stall_count +1 on each cycle with pc_write==0.
//    - flush_count +1 on each cycle with branch_taken==1.
//    - Both saturate at all-ones, never wrap. Reset clears both.
//  Not defined: counter logic is absent; stall_count and flush_count are tied to 0. Ports remain for interface stability.
// STRUCTURE
//  Package hazard_pkg:
//    - state enum {RUN, STALL}
//    - localparam REG_XZR = 5'd31
//    - localparam NOP_CTRL (all-zero control bundle)
//  Sub-module hazard_perf_cnt (one saturating CNT_W counter with inc/clear), instantiated twice under the macro.
// TESTING
//  1 LDUR X2 in EX, ADD reads X2 as Rn, default params -> one cycle pc_write=0, id_ex_bubble=1, then pc_write=1.
//  2 Load writes X31, decode reads X31 -> no stall, pc_write stays 1.
//  3 LOAD_STALL_CYCLES=3, hazard on reg2 with uses_reg2=1 -> exactly 3 stall cycles; with uses_reg2=0 -> 0 cycles.
//  4 branch_taken during 2nd STALL cycle -> all three flushes =1 that cycle, state=RUN next cycle, pc_write=1.
//  5 Hazard and branch_taken same cycle -> flushes=1, id_ex_bubble=0, stall_count unchanged.
//  6 HAZARD_PERF_CNT_EN, CNT_W=4, 20 stall cycles -> stall_count=4'hF. Reset -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the load-use / branch hazard controller.
//   Contents:
//     state_t   : controller FSM state {RUN, STALL}
//     REG_XZR   : architectural zero register index (never a hazard source)
//     ex_ctrl_t : ID/EX control bundle layout; NOP_CTRL is its all-zero bubble
//     load_use(): load-use hazard predicate shared by decode-side logic
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [4:0] REG_XZR = 5'd31;

  // Control fields carried by ID/EX; a bubble loads all of them as zero.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_CTRL = '0;

  // A load in EX hazards the decode instruction when its destination is a
  // real register read by decode. reg2 only counts when decode actually uses it.
  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] write_reg,
    input logic [4:0] read_reg1,
    input logic [4:0] read_reg2,
    input logic       uses_reg2
  );
    return mem_read && (write_reg != REG_XZR) &&
           ((write_reg == read_reg1) || (uses_reg2 && (write_reg == read_reg2)));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
//   One saturating event counter. Counts cycles with i_inc high, holds at
//   all-ones instead of wrapping. Synchronous active-high clear.
//   Ports:
//     clock   in   1      rising-edge clock
//     reset   in   1      synchronous, active-high clear
//     i_inc   in   1      count this cycle
//     o_count out  CNT_W  current count
// -----------------------------------------------------------------------------
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Decode-side hazard controller. Detects load-use hazards against the load
//   sitting in EX and taken branches resolved in MEM, and drives the PC/IF-ID
//   write enables, the ID/EX bubble and the per-stage flushes. Outputs are
//   combinational so they act in the cycle the condition is seen.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
//   performance counters. Without it the counter ports are tied to zero.
//
//   Ports:
//     clock, reset          rising-edge clock, synchronous active-high reset
//     id_ex_MemRead         instruction in EX is a load
//     id_ex_write_reg       destination register of the instruction in EX
//     if_id_read_reg1/2     source registers of the instruction in decode
//     if_id_uses_reg2       decode instruction actually reads read_reg2
//     branch_taken          branch resolved taken in MEM
//     pc_write, if_id_write front-end write enables (0 = hold)
//     id_ex_bubble          load NOP controls into ID/EX
//     if_id_flush, id_ex_flush, ex_mem_flush   wrong-path squash
//     stall_count, flush_count                 performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,   // 1..15
  parameter int CNT_W             = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_write_reg,
  input  logic [4:0]       if_id_read_reg1,
  input  logic [4:0]       if_id_read_reg2,
  input  logic             if_id_uses_reg2,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // The hazard cycle itself is the first stall cycle, so STALL covers the rest.
  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_hz;

  assign w_hz = load_use(id_ex_MemRead, id_ex_write_reg, if_id_read_reg1,
                         if_id_read_reg2, if_id_uses_reg2);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!reset) begin
      if (branch_taken) begin
        // Wrong-path squash outranks any stall; the front end must refetch.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if ((r_state == STALL) || w_hz) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else if (branch_taken) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hz && (LOAD_STALL_CYCLES > 1)) begin
            r_state <= STALL;
            r_cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          // hz is not re-evaluated here: EX now holds the bubble, not the load.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (~pc_write),
    .o_count (stall_count)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (branch_taken),
    .o_count (flush_count)
  );
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Drives three hazard_ctrl instances (1, 3 and 5 stall cycles; the last with
//   4-bit counters) with the same inputs and compares every output each cycle
//   against a model that tracks "stall cycles still owed" per instance.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic       mem_read;
  logic [4:0] wr_reg;
  logic [4:0] rd_reg1;
  logic [4:0] rd_reg2;
  logic       uses2;
  logic       br;

  logic        a_pcw, a_ifw, a_bub, a_f1, a_f2, a_f3;
  logic        b_pcw, b_ifw, b_bub, b_f1, b_f2, b_f3;
  logic        c_pcw, c_ifw, c_bub, c_f1, c_f2, c_f3;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance.
  int          n_stall [3] = '{1, 3, 5};
  longint      cnt_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int          owed    [3];
  longint      scnt    [3];
  longint      fcnt    [3];

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .id_ex_MemRead(mem_read), .id_ex_write_reg(wr_reg),
    .if_id_read_reg1(rd_reg1), .if_id_read_reg2(rd_reg2), .if_id_uses_reg2(uses2),
    .branch_taken(br), .pc_write(a_pcw), .if_id_write(a_ifw), .id_ex_bubble(a_bub),
    .if_id_flush(a_f1), .id_ex_flush(a_f2), .ex_mem_flush(a_f3),
    .stall_count(a_sc), .flush_count(a_fc));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (
    .clock(clock), .reset(reset), .id_ex_MemRead(mem_read), .id_ex_write_reg(wr_reg),
    .if_id_read_reg1(rd_reg1), .if_id_read_reg2(rd_reg2), .if_id_uses_reg2(uses2),
    .branch_taken(br), .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_bubble(b_bub),
    .if_id_flush(b_f1), .id_ex_flush(b_f2), .ex_mem_flush(b_f3),
    .stall_count(b_sc), .flush_count(b_fc));

  hazard_ctrl #(.LOAD_STALL_CYCLES(5), .CNT_W(4)) dut_c (
    .clock(clock), .reset(reset), .id_ex_MemRead(mem_read), .id_ex_write_reg(wr_reg),
    .if_id_read_reg1(rd_reg1), .if_id_read_reg2(rd_reg2), .if_id_uses_reg2(uses2),
    .branch_taken(br), .pc_write(c_pcw), .if_id_write(c_ifw), .id_ex_bubble(c_bub),
    .if_id_flush(c_f1), .id_ex_flush(c_f2), .ex_mem_flush(c_f3),
    .stall_count(c_sc), .flush_count(c_fc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mr, input logic [4:0] wr,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2, input logic b);
    reset    = rst;
    mem_read = mr;
    wr_reg   = wr;
    rd_reg1  = r1;
    rd_reg2  = r2;
    uses2    = u2;
    br       = b;
  endtask

  // One clock cycle: settle, compare all outputs against the model, clock, advance the model.
  task automatic step(input string tag);
    logic       hz;
    logic [5:0] exp_ctl [3];
    logic [5:0] obs_ctl [3];
    logic [63:0] obs_sc [3];
    logic [63:0] obs_fc [3];
    #2;
    hz = mem_read && (wr_reg != 5'd31) &&
         ((wr_reg == rd_reg1) || (uses2 && (wr_reg == rd_reg2)));
    obs_ctl[0] = {a_pcw, a_ifw, a_bub, a_f1, a_f2, a_f3};
    obs_ctl[1] = {b_pcw, b_ifw, b_bub, b_f1, b_f2, b_f3};
    obs_ctl[2] = {c_pcw, c_ifw, c_bub, c_f1, c_f2, c_f3};
    obs_sc[0] = 64'(a_sc); obs_sc[1] = 64'(b_sc); obs_sc[2] = 64'(c_sc);
    obs_fc[0] = 64'(a_fc); obs_fc[1] = 64'(b_fc); obs_fc[2] = 64'(c_fc);
    for (int k = 0; k < 3; k++) begin
      // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush}
      if (reset)                   exp_ctl[k] = 6'b110000;
      else if (br)                 exp_ctl[k] = 6'b110111;
      else if (owed[k] > 0 || hz)  exp_ctl[k] = 6'b001000;
      else                         exp_ctl[k] = 6'b110000;
      check($sformatf("%s.ctl[%0d]", tag, k), 64'(obs_ctl[k]), 64'(exp_ctl[k]));
      check($sformatf("%s.stall_count[%0d]", tag, k), obs_sc[k], 64'(scnt[k]));
      check($sformatf("%s.flush_count[%0d]", tag, k), obs_fc[k], 64'(fcnt[k]));
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        owed[k] = 0;
        scnt[k] = 0;
        fcnt[k] = 0;
      end else begin
`ifdef HAZARD_PERF_CNT_EN
        if (exp_ctl[k][5] == 1'b0 && scnt[k] < cnt_max[k]) scnt[k]++;
        if (br && fcnt[k] < cnt_max[k]) fcnt[k]++;
`endif
        if (br)               owed[k] = 0;
        else if (owed[k] > 0) owed[k]--;
        else if (hz)          owed[k] = n_stall[k] - 1;
      end
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int unsigned v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 5'd31 : 5'(v);
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    // Establish known flop state before the first comparison.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;

    // Reset held with a hazard present: outputs must stay at run values.
    drive(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
    step("reset_hz");
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("idle0");

    // LDUR X2 in EX, ADD reads X2 as Rn; then EX holds the bubble.
    drive(1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b1, 1'b0);
    step("ld_use_rn");
    drive(1'b0, 1'b0, 5'd0, 5'd2, 5'd7, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("drain1");

    // Load writes XZR, decode reads XZR: no stall.
    drive(1'b0, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0);
    step("xzr");
    step("xzr2");

    // Hazard on reg2 only, with and without uses_reg2.
    drive(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
    step("rm_used");
    drive(1'b0, 1'b0, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step("drain2");
    drive(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);
    step("rm_unused");
    step("rm_unused2");

    // Branch during the second stall cycle aborts the stall.
    drive(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    step("br_abort_hz");
    drive(1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1);
    step("br_abort_br");
    drive(1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0);
    step("br_abort_after");

    // Hazard and branch in the same cycle: flush wins, no stall counted.
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    step("hz_and_br");
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("hz_and_br_after");

    // Reset arriving mid-stall leaves no residual stall.
    drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    step("rst_mid_hz");
    drive(1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    step("rst_mid_stall");
    drive(1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    step("rst_mid_rst");
    drive(1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
    step("rst_mid_after");

    // 20 consecutive stall cycles: the 4-bit counter saturates at 15.
    drive(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat_stall");
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("sat_drain");
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("sat_reset");
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step("sat_cleared");

    // Randomized traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), pick_reg(),
            pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
